sum_window_acc: RTL and testbench



---
 rtl/sum_window_acc.sv | 79 +++++++
 tb/tb_sum_window_acc.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/sum_window_acc.sv
// sum_window_acc: accumulates WINDOW accepted sums into a saturating total held on a valid/ready output.
module sum_window_acc #(
    parameter int IN_W   = 4,
    parameter int ACC_W  = 8,
    parameter int WINDOW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_sat
);
    localparam int CNT_W = (WINDOW < 2) ? 1 : $clog2(WINDOW + 1);
    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx, out_sum_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             sat, sat_nx, out_valid_nx, out_sat_nx;
    logic [ACC_W:0]   sum;
    logic             accept;
    assign in_ready = (state != HOLD);
    assign accept   = in_valid && in_ready;
    assign sum      = {1'b0, acc} + (ACC_W + 1)'(in_data);
    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        sat_nx       = sat;
        out_valid_nx = out_valid;
        out_sum_nx   = out_sum;
        out_sat_nx   = out_sat;
        if (clear) begin
            state_nx     = IDLE;
            acc_nx       = '0;
            cnt_nx       = '0;
            sat_nx       = 1'b0;
            out_valid_nx = 1'b0;
            out_sat_nx   = 1'b0;
        end else if (accept) begin
            // the first sample of a window restarts acc and the sticky saturation flag
            acc_nx = (state == IDLE) ? ACC_W'(in_data) : (sum[ACC_W] ? '1 : sum[ACC_W-1:0]);
            sat_nx = (state == IDLE) ? 1'b0 : (sat | sum[ACC_W]);
            cnt_nx = (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
            state_nx = (cnt_nx == CNT_W'(WINDOW)) ? HOLD : ACCUM;
            if (cnt_nx == CNT_W'(WINDOW)) begin
                out_valid_nx = 1'b1;
                out_sum_nx   = acc_nx;
                out_sat_nx   = sat_nx;
            end
        end else if (state == HOLD && out_ready) begin
            state_nx     = IDLE;
            out_valid_nx = 1'b0;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_sat   <= 1'b0;
        end else begin
            state     <= state_nx;
            acc       <= acc_nx;
            cnt       <= cnt_nx;
            sat       <= sat_nx;
            out_valid <= out_valid_nx;
            out_sum   <= out_sum_nx;
            out_sat   <= out_sat_nx;
        end
    end
endmodule

// File: tb/tb_sum_window_acc.sv
// tb_sum_window_acc: drives an 8-bit and a 5-bit accumulator with identical stimulus and
// checks both against a window-of-samples reference model.
module tb_sum_window_acc;
    localparam int WINDOW = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = '0;
    logic       out_ready = 1'b0;
    logic       in_ready8, out_valid8, out_sat8;
    logic [7:0] out_sum8;
    logic       in_ready5, out_valid5, out_sat5;
    logic [4:0] out_sum5;
    int tests = 0;
    int fails = 0;
    int unsigned win[$];
    bit         pend = 1'b0;
    int         total = 0;

    always #5 clk = ~clk;

    sum_window_acc #(.IN_W(4), .ACC_W(8), .WINDOW(WINDOW)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready8),
        .in_data(in_data), .out_valid(out_valid8), .out_ready(out_ready),
        .out_sum(out_sum8), .out_sat(out_sat8)
    );
    sum_window_acc #(.IN_W(4), .ACC_W(5), .WINDOW(WINDOW)) dut5 (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready5),
        .in_data(in_data), .out_valid(out_valid5), .out_ready(out_ready),
        .out_sum(out_sum5), .out_sat(out_sat5)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("in_ready8", {31'd0, in_ready8}, {31'd0, !pend});
        chk("in_ready5", {31'd0, in_ready5}, {31'd0, !pend});
        chk("out_valid8", {31'd0, out_valid8}, {31'd0, pend});
        chk("out_valid5", {31'd0, out_valid5}, {31'd0, pend});
        if (pend) begin
            // clamped total and sticky flag follow from the unclamped window total
            chk("out_sum8", {24'd0, out_sum8}, (total > 255) ? 255 : total);
            chk("out_sat8", {31'd0, out_sat8}, {31'd0, total > 255});
            chk("out_sum5", {27'd0, out_sum5}, (total > 31) ? 31 : total);
            chk("out_sat5", {31'd0, out_sat5}, {31'd0, total > 31});
        end
    endtask

    task automatic cyc(input logic v, input logic [3:0] d, input logic r, input logic c);
        bit acc_ok;
        in_valid = v; in_data = d; out_ready = r; clear = c;
        acc_ok = v && !pend;
        @(posedge clk);
        if (c) begin
            win.delete();
            pend = 1'b0;
        end else if (acc_ok) begin
            win.push_back(int'(d));
            if (win.size() == WINDOW) begin
                total = 0;
                foreach (win[i]) total += win[i];
                win.delete();
                pend = 1'b1;
            end
        end else if (pend && r) begin
            pend = 1'b0;
        end
        #1 check_model();
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d, input logic r);
        cyc(1, 4'(a), r, 0); cyc(1, 4'(b), r, 0); cyc(1, 4'(c), r, 0); cyc(1, 4'(d), r, 0);
    endtask

    task automatic async_rst();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid8", {31'd0, out_valid8}, 0);
        chk("rst_sum8", {24'd0, out_sum8}, 0);
        chk("rst_ready8", {31'd0, in_ready8}, 1);
        chk("rst_valid5", {31'd0, out_valid5}, 0);
        chk("rst_sum5", {27'd0, out_sum5}, 0);
        win.delete();
        pend = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check_model();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, out_valid8}, 0);
        chk("reset_sum", {24'd0, out_sum8}, 0);
        chk("reset_sat", {31'd0, out_sat8}, 0);
        chk("reset_ready", {31'd0, in_ready8}, 1);
        rst_n = 1'b1;
        // basic window, out_valid one cycle after the fourth accept
        feed4(2, 1, 3, 4, 1'b0);
        chk("basic_sum", {24'd0, out_sum8}, 10);
        chk("basic_ready_low", {31'd0, in_ready8}, 0);
        cyc(0, 0, 1, 0);
        chk("basic_drop", {31'd0, out_valid8}, 0);
        // gaps in in_valid with junk data
        cyc(1, 2, 0, 0); cyc(0, 9, 0, 0); cyc(0, 15, 0, 0); cyc(1, 1, 0, 0); cyc(1, 3, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 4'($urandom), 0, 0);
        chk("gap_not_yet", {31'd0, out_valid8}, 0);
        cyc(1, 4, 0, 0);
        chk("gap_sum", {24'd0, out_sum8}, 10);
        cyc(0, 0, 1, 0);
        // saturation on the 5-bit instance, then a clean window
        feed4(15, 15, 15, 15, 1'b0);
        chk("sat_sum5", {27'd0, out_sum5}, 31);
        chk("sat_flag5", {31'd0, out_sat5}, 1);
        cyc(0, 0, 1, 0);
        feed4(1, 1, 1, 1, 1'b0);
        chk("unsat_sum5", {27'd0, out_sum5}, 4);
        chk("unsat_flag5", {31'd0, out_sat5}, 0);
        cyc(0, 0, 1, 0);
        // backpressure: held result, 7s refused until after the handshake
        feed4(5, 5, 5, 5, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1, 7, 0, 0);
        chk("bp_sum", {24'd0, out_sum8}, 20);
        cyc(1, 7, 1, 0);
        cyc(1, 7, 0, 0); cyc(1, 7, 0, 0); cyc(1, 7, 0, 0);
        chk("bp_pending", {31'd0, out_valid8}, 0);
        cyc(1, 1, 0, 0);
        chk("bp_next_sum", {24'd0, out_sum8}, 22);
        cyc(0, 0, 1, 0);
        // clear mid-window (with a discarded sample) and clear during HOLD
        cyc(1, 3, 0, 0); cyc(1, 3, 0, 0); cyc(1, 9, 0, 1);
        feed4(1, 1, 1, 1, 1'b0);
        chk("clear_sum", {24'd0, out_sum8}, 4);
        chk("clear_sat", {31'd0, out_sat8}, 0);
        cyc(1, 5, 1, 1);
        chk("clear_hold", {31'd0, out_valid8}, 0);
        // async reset mid-window, then mid-HOLD
        cyc(1, 1, 0, 0); cyc(1, 2, 0, 0);
        async_rst();
        feed4(1, 2, 3, 4, 1'b0);
        chk("rst_win_sum", {24'd0, out_sum8}, 10);
        async_rst();
        feed4(1, 2, 3, 4, 1'b0);
        chk("rst_hold_sum", {24'd0, out_sum8}, 10);
        cyc(0, 0, 1, 0);
        // randomized traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 3) != 0), 4'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 31) == 0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
